// File: rtl/seq_alu.sv
// seq_alu: sequential RV32IM-style ALU with a valid/ready handshake on both sides.
// Define SEQ_ALU_MDU_EN to build the iterative multiply/divide engine; otherwise M codes return 0.
module seq_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_SLL  = 5'b00001;
    localparam logic [4:0] OP_SLT  = 5'b00010;
    localparam logic [4:0] OP_SLTU = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b01101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_result;
    logic            w_accept;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_fast;
    logic [XLEN-1:0] w_final;
    logic            w_go_busy;
    logic            w_last;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign alu_out   = r_result;
    assign w_shamt   = operand2[SHW-1:0];

    always_comb begin
        w_base = '0;
        case (alu_ctrl)
            OP_ADD:  w_base = operand1 + operand2;
            OP_SUB:  w_base = operand1 - operand2;
            OP_SLL:  w_base = operand1 << w_shamt;
            OP_SLT:  w_base = {{(XLEN-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            OP_SLTU: w_base = {{(XLEN-1){1'b0}}, (operand1 < operand2)};
            OP_XOR:  w_base = operand1 ^ operand2;
            OP_SRL:  w_base = operand1 >> w_shamt;
            OP_SRA:  w_base = $unsigned($signed(operand1) >>> w_shamt);
            OP_OR:   w_base = operand1 | operand2;
            OP_AND:  w_base = operand1 & operand2;
            default: w_base = '0;
        endcase
    end

`ifdef SEQ_ALU_MDU_EN
    localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_div;
    logic              r_neg;
    logic [SHW-1:0]    r_cnt;

    logic              w_mop;
    logic              w_is_div;
    logic              w_sgn1;
    logic              w_sgn2;
    logic              w_neg1;
    logic              w_neg2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic [XLEN-1:0]   w_special_val;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_sh;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_step_hi;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_div_res;

    assign w_mop    = alu_ctrl[4] && !alu_ctrl[3];
    assign w_is_div = alu_ctrl[2];
    // operand1 is signed for MULH, MULHSU, DIV, REM; operand2 for MULH, DIV, REM.
    assign w_sgn1 = (alu_ctrl[2:0] == 3'b001) || (alu_ctrl[2:0] == 3'b010) ||
                    (alu_ctrl[2] && !alu_ctrl[0]);
    assign w_sgn2 = (alu_ctrl[2:0] == 3'b001) || (alu_ctrl[2] && !alu_ctrl[0]);
    assign w_neg1 = w_sgn1 && operand1[XLEN-1];
    assign w_neg2 = w_sgn2 && operand2[XLEN-1];
    assign w_abs1 = w_neg1 ? -operand1 : operand1;
    assign w_abs2 = w_neg2 ? -operand2 : operand2;

    assign w_div0    = (operand2 == '0);
    assign w_ovf     = !alu_ctrl[0] && (operand1 == W_MIN) && (operand2 == '1);
    assign w_special = w_mop && w_is_div && (w_div0 || w_ovf);

    always_comb begin
        w_special_val = '0;
        if (w_div0) w_special_val = alu_ctrl[1] ? operand1 : '1;
        else        w_special_val = alu_ctrl[1] ? '0 : operand1;
    end

    assign w_go_busy = w_mop && !w_special;
    assign w_fast    = w_special ? w_special_val : w_base;
    assign w_last    = (r_state == BUSY) && (r_cnt == SHW'(XLEN-1));

    // Multiply: {hi,lo} holds accumulator and shifting multiplier. Divide: hi=remainder, lo=quotient.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_div} : '0);
    assign w_div_sh   = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_div};
    assign w_div_ge   = !w_div_diff[XLEN];
    assign w_step_hi  = r_op[2] ? (w_div_ge ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0])
                                : w_mul_sum[XLEN:1];
    assign w_step_lo  = r_op[2] ? {r_lo[XLEN-2:0], w_div_ge}
                                : {w_mul_sum[0], r_lo[XLEN-1:1]};

    assign w_prod     = {w_step_hi, w_step_lo};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_div_res  = r_op[1] ? w_step_hi : w_step_lo;

    always_comb begin
        w_final = '0;
        if (r_op[2])                w_final = r_neg ? -w_div_res : w_div_res;
        else if (r_op[1:0] == 2'b00) w_final = w_prod_fix[XLEN-1:0];
        else                        w_final = w_prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_div <= '0;
            r_neg <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op  <= alu_ctrl[2:0];
            r_hi  <= '0;
            r_lo  <= w_is_div ? w_abs1 : w_abs2;
            r_div <= w_is_div ? w_abs2 : w_abs1;
            r_neg <= (w_is_div && alu_ctrl[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
            r_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_go_busy = 1'b0;
    assign w_last    = 1'b0;
    assign w_fast    = w_base;
    assign w_final   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_go_busy ? BUSY : DONE;
            BUSY:    if (w_last) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)           r_result <= '0;
        else if (w_accept) r_result <= w_fast;
        else if (w_last)   r_result <= w_final;
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, handshake corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_seq_alu;

`ifdef SEQ_ALU_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif
    localparam int MLAT = MDU ? 33 : 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_ctrl;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctrl (alu_ctrl),
        .operand1 (operand1),
        .operand2 (operand2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_out  (alu_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Reference: plain integer arithmetic on 64-bit values, RV32M corner rules applied explicitly.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        longint          sa;
        longint          sb;
        longint          p;
        longint unsigned up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = '0;
        lat = 1;
        case (op)
            5'b00000: r = a + b;
            5'b01000: r = a - b;
            5'b00001: r = a << b[4:0];
            5'b00010: r = (sa < sb) ? 32'd1 : 32'd0;
            5'b00011: r = (a < b) ? 32'd1 : 32'd0;
            5'b00100: r = a ^ b;
            5'b00101: r = a >> b[4:0];
            5'b01101: begin p = sa >>> b[4:0]; r = p[31:0]; end
            5'b00110: r = a | b;
            5'b00111: r = a & b;
            default:  r = '0;
        endcase
        if (MDU && op[4] && !op[3]) begin
            lat = 33;
            case (op[2:0])
                3'd0: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
                3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
                3'd4: begin
                    if (b == 0) begin r = 32'hFFFFFFFF; lat = 1; end
                    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = a; lat = 1; end
                    else begin p = sa / sb; r = p[31:0]; end
                end
                3'd5: begin
                    if (b == 0) begin r = 32'hFFFFFFFF; lat = 1; end
                    else r = a / b;
                end
                3'd6: begin
                    if (b == 0) begin r = a; lat = 1; end
                    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 0; lat = 1; end
                    else begin p = sa % sb; r = p[31:0]; end
                end
                default: begin
                    if (b == 0) begin r = a; lat = 1; end
                    else r = a % b;
                end
            endcase
        end
    endfunction

    // Issues one request at a negedge with out_ready=1; returns result, latency, whether
    // in_ready stayed low until the result, and in_ready one cycle after the result.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat,
                          output logic busy_ok, output logic rdy_after);
        alu_ctrl = op; operand1 = a; operand2 = b; in_valid = 1'b1;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (!out_valid && in_ready) busy_ok = 1'b0;
        end while (!out_valid && lat < 100);
        res = alu_out;
        @(negedge clk);
        rdy_after = in_ready;
    endtask

    task automatic apply(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        logic        busy_ok;
        logic        rdy_after;
        run_op(op, a, b, res, lat, busy_ok, rdy_after);
        $display("%s op=%05b a=0x%08h b=0x%08h res=0x%08h lat=%0d", tag, op, a, b, res, lat);
        check($sformatf("%s result op=%05b", tag, op), res, exp);
        check($sformatf("%s latency op=%05b", tag, op), lat, exp_lat);
        check($sformatf("%s in_ready low while busy", tag), {31'b0, busy_ok}, 32'd1);
        check($sformatf("%s in_ready after result", tag), {31'b0, rdy_after}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rexp;
        logic [4:0]  rop;
        int          rlat;
        int          seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = '0; operand1 = '0; operand2 = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset alu_out", alu_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);

        add_vec(5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
        add_vec(5'b01000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1);
        add_vec(5'b01101, 32'h80000000, 32'h00000024, 32'hF8000000, 1);
        add_vec(5'b00011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1);
        add_vec(5'b00010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1);
        add_vec(5'b00001, 32'h00000001, 32'h00000021, 32'h00000002, 1);
        add_vec(5'b00101, 32'h80000000, 32'h0000001F, 32'h00000001, 1);
        add_vec(5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
        add_vec(5'b00110, 32'hF0F0F0F0, 32'h0000FFFF, 32'hF0F0FFFF, 1);
        add_vec(5'b00111, 32'hF0F0F0F0, 32'h0000FFFF, 32'h0000F0F0, 1);
        add_vec(5'b01001, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);
        add_vec(5'b11000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);
        add_vec(5'b00000, 32'h00000003, 32'h00000005, 32'h00000008, 1);
        add_vec(5'b10000, 32'h00000003, 32'h00000005, MDU ? 32'h0000000F : 32'h0, MLAT);
        add_vec(5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MLAT);
        add_vec(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, MDU ? 32'hFFFFFFFE : 32'h0, MLAT);
        add_vec(5'b10010, 32'hFFFFFFFF, 32'h00000002, MDU ? 32'hFFFFFFFF : 32'h0, MLAT);
        add_vec(5'b10100, 32'h80000000, 32'hFFFFFFFF, MDU ? 32'h80000000 : 32'h0, 1);
        add_vec(5'b10101, 32'h00000007, 32'h00000000, MDU ? 32'hFFFFFFFF : 32'h0, 1);
        add_vec(5'b10110, 32'hFFFFFFF9, 32'h00000002, MDU ? 32'hFFFFFFFF : 32'h0, MLAT);
        add_vec(5'b10100, 32'hFFFFFFF9, 32'h00000002, MDU ? 32'hFFFFFFFD : 32'h0, MLAT);
        add_vec(5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        add_vec(5'b10111, 32'h00000005, 32'h00000000, MDU ? 32'h00000005 : 32'h0, 1);

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Result held in DONE while out_ready is low; competing requests are ignored.
        out_ready = 1'b0;
        alu_ctrl = 5'b00000; operand1 = 32'h11; operand2 = 32'h22; in_valid = 1'b1;
        @(negedge clk);
        check("hold out_valid", {31'b0, out_valid}, 32'd1);
        held = alu_out;
        check("hold first value", held, 32'h33);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; alu_ctrl = 5'b01000; operand1 = $urandom; operand2 = $urandom;
            @(negedge clk);
            check($sformatf("hold cyc%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("hold cyc%0d alu_out", i), alu_out, 32'h33);
            check($sformatf("hold cyc%0d in_ready", i), {31'b0, in_ready}, 32'd0);
        end
        $display("hold done alu_out=0x%08h", alu_out);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("release out_valid", {31'b0, out_valid}, 32'd0);
        check("release in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        check("ignored request no result", {31'b0, out_valid}, 32'd0);

        // Reset while the operation is in flight (BUSY with the engine, DONE without it).
        out_ready = 1'b0;
        alu_ctrl = 5'b10011; operand1 = 32'hFFFFFFFF; operand2 = 32'hFFFFFFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort out_valid", {31'b0, out_valid}, 32'd0);
        check("abort alu_out", alu_out, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("abort idle in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort no result", seen, 0);
        $display("abort done seen=%0d", seen);

        for (int i = 0; i < 150; i++) begin
            rop = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0: ra = 32'h0;
                1: ra = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 40));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, rexp, rlat);
            apply($sformatf("rnd%0d", i), rop, ra, rb, rexp, rlat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter XLEN, default 32: operand/result width, power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(XLEN): shift-amount width, derived, not overridden.
REQ-003 clk  input  1  rising-edge clock; one clock, single domain.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 alu_ctrl  input  5  operation code, sampled on accept.
REQ-008 operand1  input  XLEN  first operand (rs1 / dividend / multiplicand).
REQ-009 operand2  input  XLEN  second operand (rs2 / divisor / multiplier); shifts use operand2[SHW-1:0].
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 alu_out  output  XLEN  result, stable while out_valid=1.

Function
REQ-013 Opcodes SHALL be: 00000 ADD, 01000 SUB, 00001 SLL, 00010 SLT, 00011 SLTU, 00100 XOR, 00101 SRL, 01101 SRA, 00110 OR, 00111 AND, 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU; any other code SHALL yield 0.
REQ-014 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready; operands and code are latched on accept.
REQ-016 IDLE->DONE on accept of a base op, undefined code, or M-op special case (REQ-020/021): latency 1 (out_valid the cycle after accept).
REQ-017 IDLE->BUSY on accept of any other M op; BUSY runs an XLEN-step iterative engine (shift-add multiply / restoring divide), then ->DONE: out_valid exactly XLEN+1 cycles after accept.
REQ-018 DONE: out_valid=1, alu_out held; DONE->IDLE on out_ready=1; otherwise remains in DONE indefinitely (no new accept while DONE or BUSY).
REQ-019 SLT/MULH/MULHSU/DIV/REM treat operands as two's complement per RV32M semantics; MUL returns low XLEN bits, MULH* high XLEN bits of 2*XLEN product; shifts wrap amount modulo XLEN.
REQ-020 Divide by zero: DIV/DIVU = all ones, REM/REMU = operand1.
REQ-021 Signed overflow (operand1 = most negative, operand2 = -1): DIV = operand1, REM = 0.
REQ-022 ADD/SUB wrap modulo 2^XLEN; no flags.
REQ-023 in_valid while in_ready=0 SHALL have no effect; requester holds the request.

Reset
REQ-024 On rst=1: state IDLE, out_valid=0, alu_out=0, iteration counter and engine registers 0, in_ready=1 from the cycle after reset release.
REQ-025 rst asserted in BUSY or DONE SHALL abort the operation; no result is ever presented for it.

Configuration
REQ-026 Macro SEQ_ALU_MDU_EN: defined -> M ops (bit4=1) implemented per REQ-017..021.
REQ-027 Macro undefined -> no BUSY path or engine logic; every bit4=1 code returns 0 with latency 1; base ops unchanged.

Verification
REQ-028 Reset then ADD 0x7FFFFFFF+1, out_ready=1 -> out_valid cycle after accept, alu_out=0x80000000, in_ready back next cycle.
REQ-029 SRA 0x80000000 by operand2=0x24 (amount 4) -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT same -> 0.
REQ-030 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0 and MULHU -> 0xFFFFFFFE, each with out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at latency 1; DIVU 7/0 -> 0xFFFFFFFF; REM -7/2 -> 0xFFFFFFFF.
REQ-032 out_ready held 0 for 10 cycles in DONE -> alu_out stable, in_valid ignored; rst pulse mid-BUSY -> out_valid=0, IDLE next cycle.
REQ-033 Build without SEQ_ALU_MDU_EN: MUL 3x5 -> 0 at latency 1; ADD 3+5 -> 8.
